// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between the CPU MEM stage (port 0)
// and the loader/debug port (port 1), one transaction per IDLE -> ACCESS -> DONE pass.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        mem_r,
    output logic        mem_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        accept_s;
    logic        win_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;

    logic        last_r;
    logic        win_id_r;
    logic        we_r;
    logic        gnt0_r;
    logic        gnt1_r;
    logic        ack0_r;
    logic        ack1_r;
    logic [31:0] rdata_r;
    logic        busy_r;
    logic        mem_rd_r;
    logic        mem_wr_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_din_r;

    // Winner selection: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
            win_s = ~last_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Request fields of the winning port
    always_comb begin
        sel_we_s    = we0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        if (win_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Next-state logic; ACCESS and DONE each last exactly one cycle
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Transaction latch and round-robin pointer (pointer 1 so port 0 wins the first tie)
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r   <= 1'b1;
            win_id_r <= 1'b0;
            we_r     <= 1'b0;
        end else if (accept_s) begin
            last_r   <= win_s;
            win_id_r <= win_s;
            we_r     <= sel_we_s;
        end else begin
            last_r   <= last_r;
            win_id_r <= win_id_r;
            we_r     <= we_r;
        end
    end

    // Grant and memory-side registers: loaded on IDLE exit so they are live only during ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_wr_r   <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_din_r  <= 32'd0;
        end else if (accept_s) begin
            gnt0_r     <= ~win_s;
            gnt1_r     <= win_s;
            mem_rd_r   <= ~sel_we_s;
            mem_wr_r   <= sel_we_s;
            mem_addr_r <= sel_addr_s;
            mem_din_r  <= sel_wdata_s;
        end else begin
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_wr_r   <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_din_r  <= 32'd0;
        end
    end

    // Completion: ack pulse and read-data capture on the edge leaving DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            rdata_r <= 32'd0;
        end else if (state_r == DONE) begin
            ack0_r <= ~win_id_r;
            ack1_r <= win_id_r;
            if (!we_r) begin
                rdata_r <= mem_dout;
            end else begin
                rdata_r <= rdata_r;
            end
        end else begin
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            rdata_r <= rdata_r;
        end
    end

    // Busy mirrors the registered state being away from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
        end
    end

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign rdata    = rdata_r;
    assign busy     = busy_r;
    assign mem_r    = mem_rd_r;
    assign mem_w    = mem_wr_r;
    assign mem_addr = mem_addr_r;
    assign mem_din  = mem_din_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-schedule model checked every cycle,
// directed scenarios with hand-computed literal expectations, small data memory.
module tb_dmem_arbiter;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1, busy, mem_r, mem_w;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .busy(busy), .mem_r(mem_r), .mem_w(mem_w),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Data memory with registered read port; preloaded while rst is high
    logic [31:0] bmem [0:31];
    always @(posedge clk) begin
        if (rst) begin
            bmem[2] <= 32'd31;
            bmem[3] <= 32'd1024;
            bmem[4] <= 32'd9;
        end
        if (mem_r) mem_dout <= bmem[mem_addr[4:0]];
        if (mem_w) bmem[mem_addr[4:0]] <= mem_din;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs per cycle (cycle n = interval after clock edge n)
    bit        e_gnt0 [MAXC];
    bit        e_gnt1 [MAXC];
    bit        e_ack0 [MAXC];
    bit        e_ack1 [MAXC];
    bit        e_busy [MAXC];
    bit        e_mr   [MAXC];
    bit        e_mw   [MAXC];
    bit [31:0] e_addr [MAXC];
    bit [31:0] e_din  [MAXC];
    bit        rd_upd [MAXC];
    logic [31:0] rd_val [MAXC];
    bit        rst_at [MAXC];

    int   edge_cnt = 0;
    bit   started = 1'b0;
    logic [31:0] ref_mem [0:31];

    // Model: an accepted request occupies three cycles; grant now, ack two cycles later
    initial begin : model
        int free_at;
        bit m_last;
        bit w;
        bit twe;
        logic [31:0] tad, twd;
        free_at = 0;
        m_last = 1'b1;
        forever begin
            @(posedge clk);
            if (rst) begin
                started = 1'b1;
                for (int c = edge_cnt; c < MAXC; c++) begin
                    e_gnt0[c] = 1'b0; e_gnt1[c] = 1'b0; e_ack0[c] = 1'b0; e_ack1[c] = 1'b0;
                    e_busy[c] = 1'b0; e_mr[c] = 1'b0; e_mw[c] = 1'b0;
                    e_addr[c] = 32'd0; e_din[c] = 32'd0; rd_upd[c] = 1'b0; rst_at[c] = 1'b0;
                end
                rst_at[edge_cnt] = 1'b1;
                m_last = 1'b1;
                free_at = edge_cnt + 1;
                ref_mem[2] = 32'd31;
                ref_mem[3] = 32'd1024;
                ref_mem[4] = 32'd9;
            end else if (started && edge_cnt >= free_at && (req0 || req1) && edge_cnt + 2 < MAXC) begin
                w = (req0 && req1) ? !m_last : (req0 ? 1'b0 : 1'b1);
                m_last = w;
                twe = w ? we1 : we0;
                tad = w ? addr1 : addr0;
                twd = w ? wdata1 : wdata0;
                if (w) begin e_gnt1[edge_cnt] = 1'b1; e_ack1[edge_cnt + 2] = 1'b1; end
                else   begin e_gnt0[edge_cnt] = 1'b1; e_ack0[edge_cnt + 2] = 1'b1; end
                e_mr[edge_cnt] = !twe;
                e_mw[edge_cnt] = twe;
                e_addr[edge_cnt] = tad;
                e_din[edge_cnt] = twd;
                e_busy[edge_cnt] = 1'b1;
                e_busy[edge_cnt + 1] = 1'b1;
                if (twe) ref_mem[tad[4:0]] = twd;
                else begin
                    rd_upd[edge_cnt + 2] = 1'b1;
                    rd_val[edge_cnt + 2] = ref_mem[tad[4:0]];
                end
                free_at = edge_cnt + 3;
            end
            edge_cnt++;
        end
    end

    // Per-cycle comparison against the model plus structural invariants
    initial begin : cmp
        int c;
        logic [31:0] exp_rdata;
        exp_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (started && edge_cnt > 0 && edge_cnt <= MAXC) begin
                c = edge_cnt - 1;
                if (rst_at[c]) exp_rdata = 32'd0;
                else if (rd_upd[c]) exp_rdata = rd_val[c];
                chk("gnt0", {31'd0, gnt0}, {31'd0, e_gnt0[c]});
                chk("gnt1", {31'd0, gnt1}, {31'd0, e_gnt1[c]});
                chk("ack0", {31'd0, ack0}, {31'd0, e_ack0[c]});
                chk("ack1", {31'd0, ack1}, {31'd0, e_ack1[c]});
                chk("busy", {31'd0, busy}, {31'd0, e_busy[c]});
                chk("mem_r", {31'd0, mem_r}, {31'd0, e_mr[c]});
                chk("mem_w", {31'd0, mem_w}, {31'd0, e_mw[c]});
                chk("mem_addr", mem_addr, e_addr[c]);
                chk("mem_din", mem_din, e_din[c]);
                chk("rdata", rdata, exp_rdata);
                chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
                chk("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
                chk("strobe_excl", {31'd0, mem_r & mem_w}, 32'd0);
                if (!(gnt0 || gnt1)) begin
                    chk("idle_strobes", {30'd0, mem_r, mem_w}, 32'd0);
                    chk("idle_addr", mem_addr, 32'd0);
                    chk("idle_din", mem_din, 32'd0);
                end
            end
        end
    end

    // Directed stimulus, driven on the falling edge
    initial begin : stim
        int gp [8];
        int gc [8];
        int ng;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // single read of addr 2
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd2;
        @(negedge clk);
        chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rd_mem_r", {31'd0, mem_r}, 32'd1);
        chk("rd_addr", mem_addr, 32'd2);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_ack0", {31'd0, ack0}, 32'd1);
        chk("rd_data", rdata, 32'd31);

        // single write from port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd5; wdata1 = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_gnt1", {31'd0, gnt1}, 32'd1);
        chk("wr_mem_w", {31'd0, mem_w}, 32'd1);
        chk("wr_din", mem_din, 32'hDEADBEEF);
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wr_ack1", {31'd0, ack1}, 32'd1);
        chk("wr_keeps_rdata", rdata, 32'd31);

        // read back the written word
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rb_data", rdata, 32'hDEADBEEF);

        // tie after reset: grants alternate 0,1,0,1 every three cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; addr0 = 32'd3; req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((gnt0 || gnt1) && ng < 8) begin
                gp[ng] = gnt1 ? 1 : 0;
                gc[ng] = i;
                ng++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_count", ng, 32'd4);
        for (int k = 0; k < 4 && k < ng; k++) begin
            chk("tie_port", gp[k], k % 2);
            chk("tie_spacing", gc[k], 3 * k);
        end
        @(negedge clk);

        // back-to-back reads with req0 re-presented in the IDLE cycle
        req0 = 1'b1; addr0 = 32'd3;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        chk("b2b_busy_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("b2b_ack_a", {31'd0, ack0}, 32'd1);
        chk("b2b_data_a", rdata, 32'd1024);
        chk("b2b_busy_gap", {31'd0, busy}, 32'd0);
        req0 = 1'b1; addr0 = 32'd4;
        @(negedge clk);
        chk("b2b_busy_again", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_ack_b", {31'd0, ack0}, 32'd1);
        chk("b2b_data_b", rdata, 32'd9);

        // reset during DONE of a read aborts it
        req0 = 1'b1; addr0 = 32'd2;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ack0", {31'd0, ack0}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        @(negedge clk);
        chk("post_gnt1", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_ack1", {31'd0, ack1}, 32'd1);
        chk("post_data", rdata, 32'd9);
        req0 = 1'b1; addr0 = 32'd3; req1 = 1'b1; addr1 = 32'd2;
        @(negedge clk);
        chk("post_tie_port0", {30'd0, gnt0, gnt1}, 32'd2);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_tie_data", rdata, 32'd1024);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
